// File: rtl/mult_accum_pkg.sv
// Shared types and default sizes for the product-block accumulator stage.
package mult_accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  localparam int WIDTHP_DEF   = 20;
  localparam int WIDTHACC_DEF = 32;
  localparam int LENW_DEF     = 8;

endpackage

// File: rtl/mult_accum_out_reg.sv
// Single-entry valid/ready holding register for finished block sums.
// A load at the same edge as a take replaces the entry without a bubble.
module mult_accum_out_reg
  import mult_accum_pkg::*;
#(
  parameter int W = WIDTHACC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_load_ovf,
  input  logic         i_take,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_ovf
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         r_ovf;

  // Holding register: load has priority over take so back-to-back results stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= {W{1'b0}};
      r_ovf   <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_load_data;
      r_ovf   <= i_load_ovf;
    end else if (i_take && r_valid) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/mult_accum_dump.sv
// Accumulates blocks of blk_len unsigned products into one modulo-2**WIDTHACC sum
// and hands each finished sum to a valid/ready holding register.
module mult_accum_dump
  import mult_accum_pkg::*;
#(
  parameter int WIDTHP   = WIDTHP_DEF,
  parameter int WIDTHACC = WIDTHACC_DEF,
  parameter int LENW     = LENW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTHP-1:0]   in_data,
  input  logic [LENW-1:0]     blk_len,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTHACC-1:0] out_data,
  output logic                out_ovf,
  output logic                busy
);

  localparam int ACCW1 = WIDTHACC + 1;

  state_e              r_state;
  logic [WIDTHACC-1:0] r_acc;
  logic [LENW-1:0]     r_cnt;
  logic [LENW-1:0]     r_len_q;
  logic                r_ovf;

  state_e              w_state_nxt;
  logic [WIDTHACC-1:0] w_acc_nxt;
  logic [LENW-1:0]     w_cnt_nxt;
  logic [LENW-1:0]     w_len_nxt;
  logic                w_ovf_nxt;
  logic                w_load;

  logic [LENW-1:0]     w_len_eff;
  logic                w_final_pending;
  logic                w_accept;
  logic [WIDTHACC:0]   w_sum_ext;
  logic                w_out_valid;

  // A block length of zero behaves as a single-beat block.
  assign w_len_eff       = (blk_len == {LENW{1'b0}}) ? LENW'(1) : blk_len;
  assign w_final_pending = (r_state == ACCUM) ? (r_cnt == (r_len_q - LENW'(1)))
                                              : (w_len_eff == LENW'(1));
  assign in_ready        = !(w_final_pending && w_out_valid && !out_ready);
  assign w_accept        = in_valid && in_ready;
  assign w_sum_ext       = {1'b0, r_acc} + ACCW1'(in_data);

  // Next-state, counter and accumulator update for the block FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len_q;
    w_ovf_nxt   = r_ovf;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_len_nxt = w_len_eff;
          w_acc_nxt = WIDTHACC'(in_data);
          w_ovf_nxt = 1'b0;
          if (w_final_pending) begin
            w_cnt_nxt = {LENW{1'b0}};
            w_load    = 1'b1;
          end else begin
            w_cnt_nxt   = LENW'(1);
            w_state_nxt = ACCUM;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_acc_nxt = w_sum_ext[WIDTHACC-1:0];
          w_ovf_nxt = r_ovf | w_sum_ext[WIDTHACC];
          if (w_final_pending) begin
            w_cnt_nxt   = {LENW{1'b0}};
            w_load      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + LENW'(1);
          end
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Block FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= {WIDTHACC{1'b0}};
      r_cnt   <= {LENW{1'b0}};
      r_len_q <= {LENW{1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len_q <= w_len_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  mult_accum_out_reg #(
    .W (WIDTHACC)
  ) u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_load_data (w_acc_nxt),
    .i_load_ovf  (w_ovf_nxt),
    .i_take      (out_ready),
    .o_valid     (w_out_valid),
    .o_data      (out_data),
    .o_ovf       (out_ovf)
  );

  assign out_valid = w_out_valid;
  assign busy      = (r_state == ACCUM);

endmodule

// File: tb/tb_mult_accum_dump.sv
// Directed scoreboard bench for mult_accum_dump (accumulator width 20 to exercise wrap).
module tb_mult_accum_dump;

  localparam int WP = 20;
  localparam int WA = 20;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [WP-1:0] in_data;
  logic [LW-1:0] blk_len;
  logic          out_valid;
  logic          out_ready;
  logic [WA-1:0] out_data;
  logic          out_ovf;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [WA:0] exp_q[$];

  mult_accum_dump #(.WIDTHP(WP), .WIDTHACC(WA), .LENW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .blk_len(blk_len), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [WA-1:0] d, input logic o);
    exp_q.push_back({o, d});
  endtask

  // Drives one beat and returns one tick after the edge that accepted it.
  task automatic send(input logic [WP-1:0] d, input logic [LW-1:0] len);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    blk_len  = len;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        n_checks++;
        n_errors++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, expected 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard monitor: a result is consumed when it is presented while out_ready is high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got data=%0h ovf=%0b, expected no result", out_data, out_ovf);
      end else begin
        logic [WA:0] e;
        e = exp_q.pop_front();
        if ({out_ovf, out_data} !== e) begin
          n_errors++;
          $display("FAIL sb_result: got data=%0h ovf=%0b, expected data=%0h ovf=%0b",
                   out_data, out_ovf, e[WA-1:0], e[WA]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    blk_len   = 8'd1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {12'd0, out_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset mid-block with a result pending: both discarded.
    send(20'd7, 8'd1);
    send(20'd3, 8'd2);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_data", {12'd0, out_data}, 32'd0);
    check("async_rst_ovf", {31'd0, out_ovf}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Block of 4, single out_valid pulse right after the final beat.
    out_ready = 1'b1;
    push_exp(20'd10, 1'b0);
    send(20'd1, 8'd4);
    send(20'd2, 8'd4);
    send(20'd3, 8'd4);
    check("b4_busy", {31'd0, busy}, 32'd1);
    send(20'd4, 8'd4);
    check("b4_valid_after_final", {31'd0, out_valid}, 32'd1);
    check("b4_data", {12'd0, out_data}, 32'd10);
    @(posedge clk);
    #1;
    check("b4_single_pulse", {31'd0, out_valid}, 32'd0);

    // Backpressure: only the beat that would overwrite the held result stalls.
    out_ready = 1'b0;
    push_exp(20'd11, 1'b0);
    push_exp(20'd15, 1'b0);
    send(20'd5, 8'd2);
    send(20'd6, 8'd2);
    send(20'd7, 8'd2);
    in_valid = 1'b1;
    in_data  = 20'd8;
    @(negedge clk);
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
    check("stall_hold_data", {12'd0, out_data}, 32'd11);
    out_ready = 1'b1;
    @(negedge clk);
    check("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("load_take_valid", {31'd0, out_valid}, 32'd1);
    check("load_take_data", {12'd0, out_data}, 32'd15);
    @(posedge clk);
    #1;

    // Single-beat blocks stream without bubbles.
    push_exp(20'd3, 1'b0);
    push_exp(20'd9, 1'b0);
    push_exp(20'd4, 1'b0);
    send(20'd3, 8'd1);
    check("b2b_valid0", {31'd0, out_valid}, 32'd1);
    send(20'd9, 8'd1);
    check("b2b_valid1", {31'd0, out_valid}, 32'd1);
    send(20'd4, 8'd1);
    check("b2b_valid2", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    check("b2b_end", {31'd0, out_valid}, 32'd0);

    // Wrap and per-block overflow flag.
    push_exp(20'h00001, 1'b1);
    send(20'hFFFFF, 8'd2);
    send(20'h00002, 8'd2);
    push_exp(20'd2, 1'b0);
    send(20'd1, 8'd2);
    send(20'd1, 8'd2);
    push_exp(20'h00004, 1'b1);
    send(20'hFFFFF, 8'd3);
    send(20'h00002, 8'd3);
    send(20'h00003, 8'd3);

    // Zero length acts as one; length changes mid-block are ignored.
    push_exp(20'd6, 1'b0);
    send(20'd6, 8'd0);
    check("len0_valid", {31'd0, out_valid}, 32'd1);
    push_exp(20'd6, 1'b0);
    send(20'd1, 8'd3);
    send(20'd2, 8'd5);
    send(20'd3, 8'd5);
    check("len_change_closed", {31'd0, out_valid}, 32'd1);
    check("len_change_idle", {31'd0, busy}, 32'd0);
    push_exp(20'd30, 1'b0);
    send(20'd10, 8'd2);
    send(20'd20, 8'd2);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("sb_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
